// File: rtl/apb_master_arbiter_if.sv
// Bundled bus for apb_master_arbiter: two requester channels plus the APB master side.
// The master modport is the arbiter's view; slave is the environment's view.
interface apb_master_arbiter_if #(
    parameter int unsigned APB_BUS_W  = 32,
    parameter int unsigned APB_ADDR_W = 32
);
    logic                  m0_valid;
    logic                  m0_ready;
    logic [APB_ADDR_W-1:0] m0_addr;
    logic                  m0_write;
    logic [APB_BUS_W-1:0]  m0_wdata;
    logic                  m0_rsp_valid;
    logic [APB_BUS_W-1:0]  m0_rdata;
    logic                  m0_err;

    logic                  m1_valid;
    logic                  m1_ready;
    logic [APB_ADDR_W-1:0] m1_addr;
    logic                  m1_write;
    logic [APB_BUS_W-1:0]  m1_wdata;
    logic                  m1_rsp_valid;
    logic [APB_BUS_W-1:0]  m1_rdata;
    logic                  m1_err;

    logic [APB_ADDR_W-1:0] paddr;
    logic [APB_BUS_W-1:0]  pwdata;
    logic                  pwrite;
    logic                  psel;
    logic                  penable;
    logic [APB_BUS_W-1:0]  prdata;
    logic                  pready;

    modport master (
        input  m0_valid, m0_addr, m0_write, m0_wdata,
        output m0_ready, m0_rsp_valid, m0_rdata, m0_err,
        input  m1_valid, m1_addr, m1_write, m1_wdata,
        output m1_ready, m1_rsp_valid, m1_rdata, m1_err,
        output paddr, pwdata, pwrite, psel, penable,
        input  prdata, pready
    );

    modport slave (
        output m0_valid, m0_addr, m0_write, m0_wdata,
        input  m0_ready, m0_rsp_valid, m0_rdata, m0_err,
        output m1_valid, m1_addr, m1_write, m1_wdata,
        input  m1_ready, m1_rsp_valid, m1_rdata, m1_err,
        input  paddr, pwdata, pwrite, psel, penable,
        output prdata, pready
    );
endinterface

// File: rtl/apb_master_arbiter.sv
// Two-requester round-robin arbiter driving a single APB master port.
// Define APB_ARB_TIMEOUT_EN to end stalled ACCESS phases after TIMEOUT_CYC cycles with err=1.
module apb_master_arbiter #(
    parameter int unsigned APB_BUS_W   = 32,
    parameter int unsigned APB_ADDR_W  = 32,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input logic                  clk,
    input logic                  reset_n,
    apb_master_arbiter_if.master bus_io
);
    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    state_e                state_q, state_d;
    logic                  last_q, last_d;    // index of the requester granted most recently
    logic                  owner_q, owner_d;
    logic [APB_ADDR_W-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [APB_BUS_W-1:0]  wdata_q, wdata_d;
    logic [1:0]            rsp_valid_q, rsp_valid_d;
    logic [1:0]            err_q, err_d;
    logic [APB_BUS_W-1:0]  rdata_q [2];
    logic [APB_BUS_W-1:0]  rdata_d [2];

    logic [1:0] valid;
    logic [1:0] ready;
    logic       grant_en;
    logic       access_done;
    logic       timeout;

    if (TIMEOUT_CYC == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

`ifdef APB_ARB_TIMEOUT_EN
    localparam int unsigned     CntW    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign timeout = (state_q == StAccess) && !bus_io.pready && (cnt_q == CntLast);

    always_comb begin
        cnt_d = '0;
        if (state_q == StAccess && !bus_io.pready && !timeout) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        valid       = {bus_io.m1_valid, bus_io.m0_valid};
        state_d     = state_q;
        last_d      = last_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        rsp_valid_d = '0;
        err_d       = err_q;
        rdata_d     = rdata_q;
        ready       = '0;

        access_done = (state_q == StAccess) && (bus_io.pready || timeout);
        grant_en    = reset_n && ((state_q == StIdle) || access_done);

        if (grant_en) begin
            if (valid == 2'b11) begin
                ready = last_q ? 2'b01 : 2'b10;
            end else begin
                ready = valid;
            end
        end

        case (state_q)
            StIdle:   if (|ready) state_d = StSetup;
            StSetup:  state_d = StAccess;
            StAccess: if (access_done) state_d = (|ready) ? StSetup : StIdle;
            default:  state_d = StIdle;
        endcase

        if (|ready) begin
            owner_d = ready[1];
            last_d  = ready[1];
            addr_d  = ready[1] ? bus_io.m1_addr  : bus_io.m0_addr;
            write_d = ready[1] ? bus_io.m1_write : bus_io.m0_write;
            wdata_d = ready[1] ? bus_io.m1_wdata : bus_io.m0_wdata;
        end

        if (access_done) begin
            rsp_valid_d[owner_q] = 1'b1;
            err_d[owner_q]       = timeout;
            rdata_d[owner_q]     = (write_q || timeout) ? '0 : bus_io.prdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            rsp_valid_q <= '0;
            err_q       <= '0;
            rdata_q[0]  <= '0;
            rdata_q[1]  <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            err_q       <= err_d;
            rdata_q[0]  <= rdata_d[0];
            rdata_q[1]  <= rdata_d[1];
        end
    end

    assign bus_io.m0_ready     = ready[0];
    assign bus_io.m1_ready     = ready[1];
    assign bus_io.m0_rsp_valid = rsp_valid_q[0];
    assign bus_io.m1_rsp_valid = rsp_valid_q[1];
    assign bus_io.m0_rdata     = rdata_q[0];
    assign bus_io.m1_rdata     = rdata_q[1];
    assign bus_io.m0_err       = err_q[0];
    assign bus_io.m1_err       = err_q[1];

    assign bus_io.paddr   = addr_q;
    assign bus_io.pwdata  = wdata_q;
    assign bus_io.pwrite  = write_q;
    assign bus_io.psel    = (state_q != StIdle);
    assign bus_io.penable = (state_q == StAccess);
endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter: latency, round-robin, wait states, reset abort,
// and (with APB_ARB_TIMEOUT_EN) the ACCESS timeout.
module tb_apb_master_arbiter;
    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fail;

    apb_master_arbiter_if #(.APB_BUS_W(32), .APB_ADDR_W(32)) bus ();

    apb_master_arbiter #(
        .APB_BUS_W  (32),
        .APB_ADDR_W (32),
        .TIMEOUT_CYC(4)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; checks follow a further #1.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    logic g [4];
    int   ng;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        bus.m0_valid = 0; bus.m0_addr = '0; bus.m0_write = 0; bus.m0_wdata = '0;
        bus.m1_valid = 0; bus.m1_addr = '0; bus.m1_write = 0; bus.m1_wdata = '0;
        bus.prdata = '0; bus.pready = 1'b0;

        // Reset state
        do_reset();
        #1;
        check_eq("rst_psel", bus.psel, 0);
        check_eq("rst_penable", bus.penable, 0);
        check_eq("rst_paddr", bus.paddr, 0);
        check_eq("rst_pwdata", bus.pwdata, 0);
        check_eq("rst_pwrite", bus.pwrite, 0);
        check_eq("rst_ready", {bus.m1_ready, bus.m0_ready}, 0);
        check_eq("rst_rsp", {bus.m1_rsp_valid, bus.m0_rsp_valid}, 0);
        check_eq("rst_rdata", {bus.m1_rdata, bus.m0_rdata}, 0);
        check_eq("rst_err", {bus.m1_err, bus.m0_err}, 0);

        // Single read, then a follow-up request issued in the rsp_valid cycle
        bus.pready = 1; bus.prdata = 32'hCAFE0001;
        bus.m0_valid = 1; bus.m0_addr = 32'h10; bus.m0_write = 0;
        #1;
        check_eq("rd_ready0", bus.m0_ready, 1);
        check_eq("rd_ready1", bus.m1_ready, 0);
        tick(); bus.m0_valid = 0; #1;
        check_eq("rd_setup_psel", bus.psel, 1);
        check_eq("rd_setup_penable", bus.penable, 0);
        check_eq("rd_setup_paddr", bus.paddr, 32'h10);
        check_eq("rd_setup_pwrite", bus.pwrite, 0);
        tick(); #1;
        check_eq("rd_access_penable", bus.penable, 1);
        check_eq("rd_access_rsp", bus.m0_rsp_valid, 0);
        tick(); bus.m0_valid = 1; bus.m0_addr = 32'h14; bus.prdata = 32'hCAFE0002; #1;
        check_eq("rd_rsp", bus.m0_rsp_valid, 1);
        check_eq("rd_rdata", bus.m0_rdata, 32'hCAFE0001);
        check_eq("rd_err", bus.m0_err, 0);
        check_eq("rd_idle_psel", bus.psel, 0);
        check_eq("rd_next_ready", bus.m0_ready, 1);
        tick(); bus.m0_valid = 0; #1;
        check_eq("rd2_rsp_pulse", bus.m0_rsp_valid, 0);
        check_eq("rd2_rdata_hold", bus.m0_rdata, 32'hCAFE0001);
        check_eq("rd2_paddr", bus.paddr, 32'h14);
        tick(); tick(); #1;
        check_eq("rd2_rsp", bus.m0_rsp_valid, 1);
        check_eq("rd2_rdata", bus.m0_rdata, 32'hCAFE0002);

        // Contested grant after reset, back-to-back with no idle gap
        do_reset();
        bus.prdata = 32'h1111; bus.pready = 1;
        bus.m0_valid = 1; bus.m0_addr = 32'h100; bus.m0_write = 0;
        bus.m1_valid = 1; bus.m1_addr = 32'h200; bus.m1_write = 0;
        #1;
        check_eq("b2b_first_m0", bus.m0_ready, 1);
        check_eq("b2b_first_m1", bus.m1_ready, 0);
        tick(); bus.m0_valid = 0; #1;
        check_eq("b2b_setup_nogrant", bus.m1_ready, 0);
        check_eq("b2b_paddr0", bus.paddr, 32'h100);
        tick(); #1;
        check_eq("b2b_access", bus.penable, 1);
        check_eq("b2b_grant_m1", bus.m1_ready, 1);
        tick(); bus.m1_valid = 0; bus.prdata = 32'h2222; #1;
        check_eq("b2b_setup_psel", bus.psel, 1);
        check_eq("b2b_setup_penable", bus.penable, 0);
        check_eq("b2b_paddr1", bus.paddr, 32'h200);
        check_eq("b2b_rsp0", bus.m0_rsp_valid, 1);
        check_eq("b2b_rdata0", bus.m0_rdata, 32'h1111);
        tick(); tick(); #1;
        check_eq("b2b_rsp1", bus.m1_rsp_valid, 1);
        check_eq("b2b_rdata1", bus.m1_rdata, 32'h2222);
        check_eq("b2b_idle", bus.psel, 0);

        // Write with three wait states
        tick();
        bus.pready = 0; bus.prdata = 32'hDEAD0000;
        bus.m1_valid = 1; bus.m1_write = 1; bus.m1_addr = 32'h20; bus.m1_wdata = 32'h55AA;
        #1;
        check_eq("wr_ready1", bus.m1_ready, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            bus.m1_valid = 0;
            bus.pready = (i == 4);
            #1;
            check_eq($sformatf("wr_paddr%0d", i), bus.paddr, 32'h20);
            check_eq($sformatf("wr_pwdata%0d", i), bus.pwdata, 32'h55AA);
            check_eq($sformatf("wr_pwrite%0d", i), bus.pwrite, 1);
            check_eq($sformatf("wr_psel%0d", i), bus.psel, 1);
            check_eq($sformatf("wr_penable%0d", i), bus.penable, (i > 0));
            check_eq($sformatf("wr_norsp%0d", i), bus.m1_rsp_valid, 0);
        end
        tick(); #1;
        check_eq("wr_rsp", bus.m1_rsp_valid, 1);
        check_eq("wr_rdata", bus.m1_rdata, 0);
        check_eq("wr_idle", bus.psel, 0);

        // Round-robin with both requesters valid continuously
        tick();
        bus.prdata = 32'hABCD; bus.pready = 1;
        bus.m0_valid = 1; bus.m0_addr = 32'h300; bus.m0_write = 0;
        bus.m1_valid = 1; bus.m1_addr = 32'h400; bus.m1_write = 0;
        ng = 0;
        for (int c = 0; c < 20 && ng < 4; c++) begin
            #1;
            if (bus.m0_ready || bus.m1_ready) begin
                check_eq("rr_onehot", bus.m0_ready & bus.m1_ready, 0);
                g[ng] = bus.m1_ready;
                ng++;
            end
            tick();
        end
        bus.m0_valid = 0; bus.m1_valid = 0;
        check_eq("rr_count", ng, 4);
        for (int k = 0; k < 4; k++) begin
            if (k < ng) check_eq($sformatf("rr_grant%0d", k), g[k], k % 2);
        end
        tick(); tick(); tick(); #1;
        check_eq("rr_drain_idle", bus.psel, 0);

        // Reset during ACCESS aborts without a response
        tick();
        bus.pready = 0;
        bus.m0_valid = 1; bus.m0_addr = 32'h500; bus.m0_write = 0;
        #1;
        check_eq("ra_ready", bus.m0_ready, 1);
        tick(); bus.m0_valid = 0;
        tick(); reset_n = 0; #1;
        check_eq("ra_in_access", bus.penable, 1);
        tick(); reset_n = 1; bus.pready = 1; #1;
        check_eq("ra_psel", bus.psel, 0);
        check_eq("ra_penable", bus.penable, 0);
        check_eq("ra_paddr", bus.paddr, 0);
        check_eq("ra_norsp_a", bus.m0_rsp_valid, 0);
        tick(); #1;
        check_eq("ra_norsp_b", bus.m0_rsp_valid, 0);
        bus.prdata = 32'h6666;
        bus.m0_valid = 1; bus.m0_addr = 32'h600;
        #1;
        check_eq("ra_next_ready", bus.m0_ready, 1);
        tick(); bus.m0_valid = 0; #1;
        check_eq("ra_next_paddr", bus.paddr, 32'h600);
        tick(); tick(); #1;
        check_eq("ra_next_rsp", bus.m0_rsp_valid, 1);
        check_eq("ra_next_rdata", bus.m0_rdata, 32'h6666);

`ifdef APB_ARB_TIMEOUT_EN
        // Stalled ACCESS ends after four cycles with an error response
        tick();
        bus.pready = 0; bus.prdata = 32'hBEEF;
        bus.m0_valid = 1; bus.m0_addr = 32'h700; bus.m0_write = 0;
        #1;
        check_eq("to_ready", bus.m0_ready, 1);
        tick(); bus.m0_valid = 0; #1;
        check_eq("to_setup", bus.penable, 0);
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            check_eq($sformatf("to_access%0d", i), {bus.psel, bus.penable}, 2'b11);
            check_eq($sformatf("to_norsp%0d", i), bus.m0_rsp_valid, 0);
        end
        tick(); #1;
        check_eq("to_psel", bus.psel, 0);
        check_eq("to_rsp", bus.m0_rsp_valid, 1);
        check_eq("to_err", bus.m0_err, 1);
        check_eq("to_rdata", bus.m0_rdata, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/apb_master_arbiter.md
APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

Interface
REQ-001 SHALL have parameter APB_BUS_W, default 32, APB data width for pwdata, prdata, mN_wdata and mN_rdata.
REQ-002 SHALL have parameter APB_ADDR_W, default 32, APB address width for paddr and mN_addr.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 16, the limit of ACCESS wait cycles, used only with APB_ARB_TIMEOUT_EN.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic samples on posedge clk.
REQ-005 SHALL have port reset_n, input, 1, reset that is synchronous and active-low.
REQ-006 SHALL have ports mN_valid (N=0,1), input, 1, requester N holds a transfer request.
REQ-007 SHALL have ports mN_ready, output, 1, request accepted this cycle.
REQ-008 SHALL have ports mN_addr, input, APB_ADDR_W, the request address.
REQ-009 SHALL have ports mN_write, input, 1, 1 = write and 0 = read.
REQ-010 SHALL have ports mN_wdata, input, APB_BUS_W, the write data.
REQ-011 SHALL have ports mN_rsp_valid, output, 1, a one-cycle completion pulse.
REQ-012 SHALL have ports mN_rdata, output, APB_BUS_W, read data, valid with mN_rsp_valid.
REQ-013 SHALL have ports mN_err, output, 1, a timeout error flag, valid with mN_rsp_valid.
REQ-014 SHALL have APB master ports paddr, output, APB_ADDR_W; pwdata, output, APB_BUS_W; pwrite, output, 1; psel, output, 1; penable, output, 1.
REQ-015 SHALL have APB master ports prdata, input, APB_BUS_W; pready, input, 1.

Function
REQ-016 SHALL implement an FSM with states IDLE, SETUP and ACCESS.
REQ-017 SHALL use these FSM transitions: IDLE->SETUP on grant; SETUP->ACCESS unconditionally; ACCESS holds while pready=0; on pready=1, ACCESS->SETUP if a grant is made that cycle, else ACCESS->IDLE.
REQ-018 SHALL make grant decisions only in IDLE, or in the ACCESS cycle with pready=1.
REQ-019 SHALL assert mN_ready combinationally for exactly one cycle in the grant cycle.
REQ-020 SHALL assert at most one mN_ready per cycle.
REQ-021 SHALL arbitrate round-robin: with both mN_valid high, grant the requester not granted last; with one valid, grant it.
REQ-022 SHALL latch mN_addr, mN_write and mN_wdata into internal registers on mN_valid && mN_ready.
REQ-023 SHALL drive paddr, pwrite and pwdata from those registers, stable from SETUP until ACCESS completion.
REQ-024 SHALL hold the last paddr, pwrite and pwdata values in IDLE.
REQ-025 SHALL drive psel=1, penable=0 in SETUP; psel=1, penable=1 in ACCESS; psel=0, penable=0 in IDLE.
REQ-026 SHALL pulse mN_rsp_valid for the owning requester one cycle after the ACCESS cycle with pready=1.
REQ-027 SHALL load mN_rdata from prdata for reads and with 0 for writes, holding mN_rdata until the next response to N.
REQ-028 SHALL deliver a single transfer with latency: grant at T, SETUP T+1, ACCESS T+2 (pready=1), rsp_valid T+3.
REQ-029 SHALL start the next SETUP at T+3 for back-to-back transfers, with no IDLE cycle.
REQ-030 SHALL ignore mN_valid deassertion before ready (protocol violation, no recovery required).
REQ-031 SHALL allow a requester to issue its next request in the same cycle as its own rsp_valid.

Reset
REQ-032 SHALL, on posedge clk with reset_n=0, enter IDLE and drive psel=0, penable=0, paddr=0, pwdata=0, pwrite=0, mN_ready=0, mN_rsp_valid=0, mN_rdata=0 and mN_err=0.
REQ-033 SHALL reset the round-robin pointer so m0 wins the first contested grant.
REQ-034 SHALL, on reset during SETUP or ACCESS, abort the transfer without response, with psel low from the reset edge.

Configuration
REQ-035 SHALL, with APB_ARB_TIMEOUT_EN defined, count consecutive ACCESS cycles with pready=0, clear the counter on leaving ACCESS, and on reaching TIMEOUT_CYC end the transfer: next state IDLE or SETUP per REQ-017, mN_rsp_valid=1, mN_err=1, mN_rdata=0.
REQ-036 SHALL, without APB_ARB_TIMEOUT_EN, wait in ACCESS indefinitely, tie mN_err to 0 and instantiate no counter.

Verification
REQ-037 SHALL cover: m0 read addr 0x10, pready=1 immediately, prdata=0xCAFE0001 -> SETUP at T+1, ACCESS at T+2, m0_rsp_valid at T+3 with m0_rdata=0xCAFE0001.
REQ-038 SHALL cover: m0 and m1 both valid in IDLE after reset -> m0 granted first, m1 SETUP in the cycle after m0's ACCESS completes, no IDLE gap.
REQ-039 SHALL cover: m1 write 0x20/0x55AA, pready low 3 cycles -> paddr/pwdata/pwrite stable for 1 SETUP + 4 ACCESS cycles, m1_rdata=0.
REQ-040 SHALL cover: both valid continuously for 4 transfers -> grants alternate m0,m1,m0,m1.
REQ-041 SHALL cover: reset_n=0 during ACCESS -> psel=penable=0 after the edge, no rsp_valid, next request proceeds normally.
REQ-042 SHALL cover, with APB_ARB_TIMEOUT_EN, TIMEOUT_CYC=4: pready held 0 -> after 4 ACCESS cycles psel drops, rsp_valid with err=1 and rdata=0.
